// File: rtl/ad9226_pkg.sv
// Shared constants, sample type and index-width helper for the AD9226 frame packer.
package ad9226_pkg;

    localparam int ADC_BITS_DEF = 12;
    localparam int SAMPLES_DEF  = 20;

    typedef logic [ADC_BITS_DEF-1:0] sample_t;

    function automatic int idx_width(input int samples);
        return $clog2(samples);
    endfunction

endpackage

// File: rtl/ad9226_sample_counter.sv
// Modulo-SAMPLES slot counter; o_last flags the slot that completes a frame.
module ad9226_sample_counter
    import ad9226_pkg::*;
#(
    parameter int SAMPLES = SAMPLES_DEF,
    parameter int IW      = idx_width(SAMPLES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic [IW-1:0] o_idx,
    output logic          o_last
);

    localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES - 1);

    logic [IW-1:0] r_idx;

    // Wrap at SAMPLES-1 explicitly; SAMPLES need not be a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_idx <= '0;
        else if (r_idx == LAST_IDX)
            r_idx <= '0;
        else
            r_idx <= r_idx + 1'b1;
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/ad9226_frame_packer.sv
// Packs SAMPLES consecutive ADC samples into one frame word with a one-cycle FIFO write strobe.
// Optional build macro AD9226_TWOS_COMP_EN: invert each sample MSB (offset binary -> two's complement).
module ad9226_frame_packer
    import ad9226_pkg::*;
#(
    parameter int ADC_BITS = ADC_BITS_DEF,
    parameter int SAMPLES  = SAMPLES_DEF
) (
    input  logic                         sys_clk,
    input  logic                         reset,
    input  logic                         fifo_full,
    input  logic [ADC_BITS-1:0]          data_in,
    output logic                         fifo_write_enable,
    output logic [ADC_BITS*SAMPLES-1:0]  data_out
);

    localparam int IW = idx_width(SAMPLES);

    function automatic logic [ADC_BITS-1:0] fmt_sample(input logic [ADC_BITS-1:0] s);
`ifdef AD9226_TWOS_COMP_EN
        return {~s[ADC_BITS-1], s[ADC_BITS-2:0]};
`else
        return s;
`endif
    endfunction

    logic [IW-1:0]                w_idx;
    logic                         w_last;
    logic [ADC_BITS-1:0]          w_sample;
    logic [ADC_BITS*SAMPLES-1:0]  w_frame;

    logic [ADC_BITS-1:0]          r_stage [SAMPLES-1];
    logic [ADC_BITS*SAMPLES-1:0]  r_data_out;
    logic                         r_wr_en;

    ad9226_sample_counter #(
        .SAMPLES (SAMPLES),
        .IW      (IW)
    ) u_counter (
        .i_clk  (sys_clk),
        .i_rst  (reset),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    assign w_sample = fmt_sample(data_in);

    // The last sample bypasses staging and goes straight into the frame word.
    always_comb begin
        w_frame = '0;
        for (int k = 0; k < SAMPLES - 1; k++)
            w_frame[k*ADC_BITS +: ADC_BITS] = r_stage[k];
        w_frame[(SAMPLES-1)*ADC_BITS +: ADC_BITS] = w_sample;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SAMPLES - 1; k++)
                r_stage[k] <= '0;
        end else begin
            for (int k = 0; k < SAMPLES - 1; k++)
                if (w_idx == IW'(k))
                    r_stage[k] <= w_sample;
        end
    end

    // fifo_full only matters at the completion edge; a full FIFO drops the whole frame.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_wr_en    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_wr_en <= w_last & ~fifo_full;
            if (w_last && !fifo_full)
                r_data_out <= w_frame;
        end
    end

    assign fifo_write_enable = r_wr_en;
    assign data_out          = r_data_out;

endmodule

// File: tb/tb_ad9226_frame_packer.sv
// Self-checking bench for ad9226_frame_packer: table vectors, corner sequences and a queue-based frame model.
module tb_ad9226_frame_packer;
    import ad9226_pkg::*;

    localparam int AB = 12;
    localparam int NS = 20;
    localparam int FW = AB * NS;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_full = 1'b0;
    sample_t       data_in = '0;
    logic          we;
    logic [FW-1:0] dout;

    int n_chk  = 0;
    int n_fail = 0;

    sample_t       q[$];
    logic [FW-1:0] exp_out = '0;
    logic          exp_we = 1'b0;
    int            cyc = 0;

    always #5 sys_clk = ~sys_clk;

    ad9226_frame_packer #(
        .ADC_BITS (AB),
        .SAMPLES  (NS)
    ) dut (
        .sys_clk           (sys_clk),
        .reset             (reset),
        .fifo_full         (fifo_full),
        .data_in           (data_in),
        .fifo_write_enable (we),
        .data_out          (dout)
    );

    function automatic sample_t conv(input sample_t s);
`ifdef AD9226_TWOS_COMP_EN
        return s ^ 12'h800;
`else
        return s;
`endif
    endfunction

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: drive, let the edge happen, update the frame model, compare.
    task automatic step(input sample_t d, input logic full);
        data_in   = d;
        fifo_full = full;
        @(posedge sys_clk);
        #1;
        cyc++;
        exp_we = 1'b0;
        if (reset) begin
            q.delete();
            exp_out = '0;
        end else begin
            q.push_back(conv(d));
            if (q.size() == NS) begin
                if (!full) begin
                    for (int k = 0; k < NS; k++)
                        exp_out[k*AB +: AB] = q[k];
                    exp_we = 1'b1;
                end
                q.delete();
            end
        end
        check("strobe", {{(FW-1){1'b0}}, we}, {{(FW-1){1'b0}}, exp_we});
        check("data_out", dout, exp_out);
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        exp_we  = 1'b0;
        exp_out = '0;
        check("async_rst_strobe", {{(FW-1){1'b0}}, we}, '0);
        check("async_rst_data", dout, '0);
    endtask

    task automatic wait_strobe(output int n, output sample_t first);
        sample_t d;
        n     = -1;
        first = sample_t'($urandom);
        for (int i = 1; i <= 2 * NS; i++) begin
            d = (i == 1) ? first : sample_t'($urandom);
            step(d, 1'b0);
            if (we === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct {
        sample_t din;
        logic    exp_we;
    } vec_t;

    typedef struct {
        int      k;
        sample_t v;
    } fld_t;

    vec_t          tv[NS];
    fld_t          fv[7];
    sample_t       basic[12];
    int            n;
    int            last_strobe;
    sample_t       first;
    logic [FW-1:0] saved;
    sample_t       exp800;

    initial begin
        basic = '{12'hF0F, 12'h909, 12'h707, 12'hE0E, 12'h000, 12'h099,
                  12'h077, 12'h0EE, 12'h000, 12'h909, 12'h707, 12'hE0E};
        for (int i = 0; i < NS; i++) begin
            tv[i].din    = (i < 12) ? basic[i] : 12'h000;
            tv[i].exp_we = (i == NS - 1);
        end
        fv = '{'{0, 12'hF0F}, '{1, 12'h909}, '{2, 12'h707}, '{3, 12'hE0E},
               '{11, 12'hE0E}, '{12, 12'h000}, '{19, 12'h000}};

        // Reset hold with toggling input
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(sample_t'($urandom), 1'b0);
            check("hold_data", dout, '0);
            check("hold_strobe", {{(FW-1){1'b0}}, we}, '0);
        end
        reset = 1'b0;

        // Basic frame from the table
        for (int i = 0; i < NS; i++) begin
            step(tv[i].din, 1'b0);
            check("tbl_strobe", {{(FW-1){1'b0}}, we}, {{(FW-1){1'b0}}, tv[i].exp_we});
        end
        for (int i = 0; i < 7; i++)
            check($sformatf("field%0d", fv[i].k), {{(FW-AB){1'b0}}, dout[fv[i].k*AB +: AB]},
                  {{(FW-AB){1'b0}}, conv(fv[i].v)});
        last_strobe = cyc;

        // Continuous streaming of zeros
        for (int i = 0; i < 2 * NS; i++) begin
            step(12'h000, 1'b0);
            if (we === 1'b1) begin
                check("stream_period", FW'(cyc - last_strobe), FW'(NS));
                last_strobe = cyc;
            end
        end

        // Drop: fifo_full toggles freely mid-frame, then is high at the completion edge
        for (int i = 0; i < NS - 1; i++)
            step(sample_t'($urandom), logic'($urandom_range(0, 1)));
        saved = dout;
        step(sample_t'($urandom), 1'b1);
        check("drop_strobe", {{(FW-1){1'b0}}, we}, '0);
        check("drop_hold", dout, saved);
        wait_strobe(n, first);
        check("after_drop_period", FW'(n), FW'(NS));
        check("after_drop_slot0", {{(FW-AB){1'b0}}, dout[AB-1:0]}, {{(FW-AB){1'b0}}, conv(first)});

        // Reset after 7 captures of a frame
        for (int i = 0; i < 7; i++)
            step(sample_t'($urandom), 1'b0);
        async_reset();
        step(sample_t'($urandom), 1'b0);
        reset = 1'b0;
        wait_strobe(n, first);
        check("post_rst_period", FW'(n), FW'(NS));
        check("post_rst_slot0", {{(FW-AB){1'b0}}, dout[AB-1:0]}, {{(FW-AB){1'b0}}, conv(first)});

        // Reset while the strobe is high clears it immediately
        async_reset();
        step(sample_t'($urandom), 1'b0);
        reset = 1'b0;

        // Randomised streaming with random FIFO back-pressure
        for (int i = 0; i < 400; i++)
            step(sample_t'($urandom), ($urandom_range(0, 3) == 0));

        // Constant 0x800 mid-scale input
        async_reset();
        step(12'h000, 1'b0);
        reset = 1'b0;
`ifdef AD9226_TWOS_COMP_EN
        exp800 = 12'h000;
`else
        exp800 = 12'h800;
`endif
        for (int i = 0; i < NS; i++)
            step(12'h800, 1'b0);
        for (int k = 0; k < NS; k++)
            check($sformatf("mid_field%0d", k), {{(FW-AB){1'b0}}, dout[k*AB +: AB]},
                  {{(FW-AB){1'b0}}, exp800});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
